motor_drive_sequencer: RTL and testbench
========================================

# motor_drive_sequencer

Sequences the H-bridge leg enables for the servo motor driver: gates the on-chip PWM stream onto exactly one bridge input (forward or reverse) and enforces a programmable dead time on every drive entry or direction change. Commands arrive from the STM32 command decoder over a valid/ready handshake. An external fault input forces both legs off until software clears it. Sits between the PWM generator and the H-bridge output pins.

## Interface
- DEAD_CYCLES, 50, clock cycles both legs are held low before any drive state is entered; legal range ≥1
- CNT_W, $clog2(DEAD_CYCLES+1), dead-time counter width; derived, not overridden
- clk  in  1  system clock; the block's only clock
- n_reset  in  1  reset; asynchronous assert, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_en  in  1  1 = drive motor, 0 = stop (coast)
- cmd_dir  in  1  0 = forward, 1 = reverse; ignored when cmd_en=0
- pwm_in  in  1  PWM stream, synchronous to clk
- fault_n  in  1  bridge fault, active-low, asynchronous to clk
- clr_fault  in  1  single-cycle pulse, leaves FAULT
- in_a  out  1  forward bridge input (registered)
- in_b  out  1  reverse bridge input (registered)
- busy  out  1  1 in DEAD
- fault_latched  out  1  1 in FAULT

## Operation
- States: IDLE, DEAD, FWD, REV, FAULT. Reset state IDLE.
- Reset values: in_a=0, in_b=0, busy=0, fault_latched=0, dead-time counter=0, target=IDLE, sync flops=1; cmd_ready=1 (IDLE) once n_reset deasserts.
- cmd_ready = 1 in IDLE, FWD, REV; 0 in DEAD, FAULT. Accept = cmd_valid & cmd_ready on a rising edge.
- IDLE: accept with cmd_en=0 → stay IDLE; cmd_en=1 → DEAD, target = FWD/REV per cmd_dir.
- FWD/REV: accept with cmd_en=1 and same direction → stay, no dead time; cmd_en=0 → DEAD, target IDLE; opposite direction → DEAD, target = new direction.
- DEAD: counter loaded with DEAD_CYCLES-1 on entry, decrements each cycle; at 0 → target state. in_a=in_b=0 throughout.
- in_a <= pwm_in & (next state == FWD); in_b <= pwm_in & (next state == REV). in_a & in_b is never 1 in any cycle, including reset.
- fault_n passes through a 2-flop synchronizer. Synced fault low → FAULT from any state, overriding any simultaneous command accept. Counter and target are discarded.
- FAULT: outputs 0, fault_latched=1. clr_fault=1 with synced fault high → DEAD, target IDLE. clr_fault while fault still low → ignored.
- Reset mid-DEAD or mid-drive: immediate return to reset values. No dead time is owed after reset because both legs are already low.

## Timing
- Command accepted at edge N: state DEAD after N; drive state after N+DEAD_CYCLES; first in_a/in_b high after edge N+DEAD_CYCLES (if pwm_in=1 in that cycle).
- Dead time seen on the pins is ≥ DEAD_CYCLES full cycles with both legs low.
- pwm_in → in_a/in_b latency: 1 cycle in a steady drive state.
- fault_n low sampled at edge k: synced low after k+1; FAULT and in_a=in_b=0 after edge k+2.
- clr_fault at edge m: DEAD after m, IDLE after m+DEAD_CYCLES.
- Same-direction re-command in FWD/REV: no output glitch; PWM gating continues cycle-for-cycle.

## Structure
- Shared package motor_pkg holds typedef enum drive_state_t {IDLE, DEAD, FWD, REV, FAULT} and the localparams DIR_FWD=1'b0 and DIR_REV=1'b1.
- One sub-module, sync_2ff (1-bit two-flop synchronizer, reset to 1), for fault_n. FSM, counter and output registers stay in the top.

## Test plan
- Reset, then IDLE with pwm_in toggling → in_a=in_b=0, cmd_ready=1, busy=0 indefinitely.
- DEAD_CYCLES=4; command en=1 dir=0 accepted at edge N, pwm_in=1 → busy=1 for 4 cycles; in_a=1 after edge N+4; in_b=0 throughout.
- In FWD, command dir=1 → in_a drops next cycle; both legs low for ≥4 cycles; then in_b follows pwm_in. Assert in_a & in_b never 1.
- In REV, fault_n low at edge k while cmd_valid=1 → in_b=0 and fault_latched=1 after k+2; cmd_ready=0; command not accepted.
- clr_fault with fault_n still low → remains in FAULT. Release fault_n, then clr_fault → busy for 4 cycles, then IDLE with cmd_ready=1.
- n_reset asserted mid-DEAD → outputs 0 immediately. After release: IDLE, and a new command gets the full dead time.

Source files
------------

// File: rtl/motor_pkg.sv
// motor_pkg: shared state encoding and direction constants for the H-bridge sequencer
package motor_pkg;
    typedef enum logic [2:0] {IDLE, DEAD, FWD, REV, FAULT} drive_state_t;
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level, resets to 1
module sync_2ff (
    input  logic clk_i,
    input  logic n_reset_i,
    input  logic d_i,
    output logic q_o
);
    logic s1_q, s2_q;
    // shift the asynchronous level through two flops to settle metastability
    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end
    assign q_o = s2_q;
endmodule

// File: rtl/motor_drive_sequencer.sv
// motor_drive_sequencer: gates PWM onto one H-bridge leg with dead time and fault lockout
module motor_drive_sequencer
    import motor_pkg::*;
#(
    parameter int DEAD_CYCLES = 50
) (
    input  logic clk_i,
    input  logic n_reset_i,
    input  logic cmd_valid_i,
    output logic cmd_ready_o,
    input  logic cmd_en_i,
    input  logic cmd_dir_i,
    input  logic pwm_in_i,
    input  logic fault_n_i,
    input  logic clr_fault_i,
    output logic in_a_o,
    output logic in_b_o,
    output logic busy_o,
    output logic fault_latched_o
);
    localparam int CNT_W = $clog2(DEAD_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

    drive_state_t state_q, state_d, tgt_q, tgt_d, req;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic in_a_q, in_b_q, fault_s, accept;

    sync_2ff u_fault_sync (
        .clk_i    (clk_i),
        .n_reset_i(n_reset_i),
        .d_i      (fault_n_i),
        .q_o      (fault_s)
    );

    assign cmd_ready_o     = (state_q == IDLE) || (state_q == FWD) || (state_q == REV);
    assign busy_o          = state_q == DEAD;
    assign fault_latched_o = state_q == FAULT;
    assign in_a_o          = in_a_q;
    assign in_b_o          = in_b_q;

    // next state: fault wins, a changed request always detours through DEAD
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        accept  = cmd_valid_i & cmd_ready_o;
        req     = cmd_en_i ? ((cmd_dir_i == DIR_REV) ? REV : FWD) : IDLE;
        if (!fault_s) begin
            state_d = FAULT;
            cnt_d   = '0;
            tgt_d   = IDLE;
        end else begin
            case (state_q)
                IDLE, FWD, REV: if (accept && req != state_q) begin
                    state_d = DEAD;
                    cnt_d   = DEAD_LOAD;
                    tgt_d   = req;
                end
                DEAD: if (cnt_q == '0) state_d = tgt_q;
                      else cnt_d = cnt_q - CNT_W'(1);
                FAULT: if (clr_fault_i) begin
                    state_d = DEAD;
                    cnt_d   = DEAD_LOAD;
                    tgt_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state, counter and leg registers; legs follow the next state so they drop on the same edge
    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state_q <= IDLE;
            tgt_q   <= IDLE;
            cnt_q   <= '0;
            in_a_q  <= 1'b0;
            in_b_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            in_a_q  <= pwm_in_i & (state_d == FWD);
            in_b_q  <= pwm_in_i & (state_d == REV);
        end
    end
endmodule

// File: tb/tb_motor_drive_sequencer.sv
// tb_motor_drive_sequencer: directed plus random checks against a behavioural drive model
module tb_motor_drive_sequencer;
    localparam int DEAD = 4;

    logic clk = 1'b0, n_reset = 1'b0;
    logic cmd_valid = 1'b0, cmd_en = 1'b0, cmd_dir = 1'b0, pwm_in = 1'b0;
    logic fault_n = 1'b1, clr_fault = 1'b0;
    logic cmd_ready, in_a, in_b, busy, fault_latched;

    int n_assert = 0, n_fail = 0;

    // model: mode 0 idle, 1 fwd, 2 rev, 3 fault; dead_left > 0 means legs held low
    int mode, goal, dead_left;
    logic [1:0] fhist;
    logic exp_a, exp_b;

    motor_drive_sequencer #(.DEAD_CYCLES(DEAD)) dut (
        .clk_i          (clk),
        .n_reset_i      (n_reset),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_en_i       (cmd_en),
        .cmd_dir_i      (cmd_dir),
        .pwm_in_i       (pwm_in),
        .fault_n_i      (fault_n),
        .clr_fault_i    (clr_fault),
        .in_a_o         (in_a),
        .in_b_o         (in_b),
        .busy_o         (busy),
        .fault_latched_o(fault_latched)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode = 0; goal = 0; dead_left = 0; fhist = 2'b11; exp_a = 1'b0; exp_b = 1'b0;
    endtask

    task automatic model_step();
        logic synced;
        int want;
        synced = fhist[1];
        want = cmd_en ? (cmd_dir ? 2 : 1) : 0;
        fhist = {fhist[0], fault_n};
        if (!synced) begin
            mode = 3; dead_left = 0;
        end else if (dead_left > 0) begin
            dead_left--;
            if (dead_left == 0) mode = goal;
        end else if (mode == 3) begin
            if (clr_fault) begin mode = 0; dead_left = DEAD; goal = 0; end
        end else if (cmd_valid && want != mode) begin
            dead_left = DEAD; goal = want;
        end
        exp_a = pwm_in && mode == 1 && dead_left == 0;
        exp_b = pwm_in && mode == 2 && dead_left == 0;
    endtask

    task automatic check_all();
        chk("in_a", in_a, exp_a);
        chk("in_b", in_b, exp_b);
        chk("cmd_ready", cmd_ready, dead_left == 0 && mode != 3);
        chk("busy", busy, dead_left > 0);
        chk("fault_latched", fault_latched, mode == 3);
        chk("legs_exclusive", in_a & in_b, 1'b0);
    endtask

    task automatic tick();
        if (!n_reset) model_reset(); else model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send(input logic en, input logic dir);
        cmd_valid = 1'b1; cmd_en = en; cmd_dir = dir;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 check_all();
        tick(); tick();
        n_reset = 1'b1;
        for (int i = 0; i < 6; i++) begin pwm_in = ~pwm_in; tick(); end
        chk("idle_ready", cmd_ready, 1'b1);

        pwm_in = 1'b1;
        send(1'b1, 1'b0);
        chk("fwd_dead_0", busy, 1'b1);
        for (int i = 1; i < DEAD; i++) begin tick(); chk("fwd_dead", busy, 1'b1); end
        tick();
        chk("fwd_drive", in_a, 1'b1);
        for (int i = 0; i < 4; i++) begin pwm_in = ~pwm_in; tick(); end
        send(1'b1, 1'b0);
        chk("same_dir_ready", cmd_ready, 1'b1);

        pwm_in = 1'b1;
        send(1'b1, 1'b1);
        chk("rev_drop_a", in_a, 1'b0);
        for (int i = 0; i < DEAD - 1; i++) begin tick(); chk("rev_dead_b", in_b, 1'b0); end
        tick();
        chk("rev_drive", in_b, 1'b1);
        for (int i = 0; i < 4; i++) begin pwm_in = ~pwm_in; tick(); end

        pwm_in = 1'b1;
        fault_n = 1'b0;
        tick(); tick();
        cmd_valid = 1'b1; cmd_en = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("fault_latch", fault_latched, 1'b1);
        chk("fault_b_low", in_b, 1'b0);
        chk("fault_not_ready", cmd_ready, 1'b0);

        clr_fault = 1'b1; tick(); clr_fault = 1'b0; tick();
        chk("clr_ignored", fault_latched, 1'b1);
        fault_n = 1'b1;
        tick(); tick(); tick();
        clr_fault = 1'b1; tick(); clr_fault = 1'b0;
        chk("clr_dead_0", busy, 1'b1);
        for (int i = 1; i < DEAD; i++) begin tick(); chk("clr_dead", busy, 1'b1); end
        tick();
        chk("clr_idle_ready", cmd_ready, 1'b1);

        send(1'b1, 1'b1);
        tick();
        #2 n_reset = 1'b0;
        #1;
        model_reset();
        chk("rst_a", in_a, 1'b0);
        chk("rst_b", in_b, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        tick(); tick();
        n_reset = 1'b1;
        tick();
        send(1'b1, 1'b1);
        for (int i = 1; i < DEAD; i++) begin tick(); chk("post_rst_dead", busy, 1'b1); end
        tick();
        chk("post_rst_drive", in_b, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_en    = 1'($urandom_range(0, 3) != 0);
            cmd_dir   = 1'($urandom_range(0, 1));
            pwm_in    = 1'($urandom_range(0, 1));
            clr_fault = 1'($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 59) == 0) fault_n = ~fault_n;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
